arbiter8ne1: RTL and testbench

Round-robin arbiter and sequencer for the shared 8-to-1 source multiplexer (`mux8ne1`) in the 16-bit CPU datapath. It accepts eight request lines, grants one owner at a time with a bounded hold, and drives the multiplexer select `S` using that multiplexer's non-binary select encoding. It also flags when the multiplexer output is valid for the current owner.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rr_prio8.sv | 28 ++
 rtl/arbiter8ne1.sv | 125 ++++++++++++
 tb/tb_arbiter8ne1.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: arbiter FSM states, request/index widths
// and the select encoding of the 8-to-1 source multiplexer.
package cpu_pkg;

    localparam int REQ_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Index -> select code of mux8ne1. The mux does not use a binary select,
    // so every producer of S must go through this table.
    localparam logic [2:0] MUX8_SEL [0:7] = '{
        3'b000, 3'b010, 3'b100, 3'b011, 3'b111, 3'b001, 3'b101, 3'b110
    };

endpackage

// File: rtl/rr_prio8.sv
// Combinational round-robin priority finder: scans req starting at ptr and
// wrapping modulo 8, returning the first set position.
module rr_prio8
    import cpu_pkg::*;
(
    input  logic [REQ_N-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit to ptr wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int j = REQ_N - 1; j >= 0; j--) begin
            cand = ptr_i + IDX_W'(j);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/arbiter8ne1.sv
// Round-robin arbiter and sequencer for the shared 8-to-1 source mux.
// Grants one owner at a time with an optional hold limit, drives the mux
// select in its native encoding, and flags when the mux output is valid.
module arbiter8ne1
    import cpu_pkg::*;
#(
    parameter int MAX_HOLD = 16   // 0 disables the hold limit, legal 0..255
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REQ_N-1:0] Kerkesa,
    input  logic [REQ_N-1:0] Lirim,
    output logic [REQ_N-1:0] Leje,
    output logic [IDX_W-1:0] S,
    output logic [IDX_W-1:0] Indeksi,
    output logic             Valid,
    output logic             Timeout
);

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [7:0]       hold_q, hold_d;
    logic [REQ_N-1:0] leje_q, leje_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [IDX_W-1:0] winIdx;
    logic             ownerRelease;
    logic             holdExpired;

    rr_prio8 u_prio (
        .req_i   (Kerkesa),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (winIdx)
    );

    assign ownerRelease = Lirim[owner_q] | ~Kerkesa[owner_q];
    assign holdExpired  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: arbitrate in IDLE, leave GRANT on release or expiry, TURN lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found) state_d = ST_GRANT;
            ST_GRANT: if (ownerRelease || holdExpired) state_d = ST_TURN;
            ST_TURN:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything leaves through registers so no input reaches an output combinationally.
    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        leje_d    = '0;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = winIdx;
                    sel_d   = MUX8_SEL[winIdx];
                    hold_d  = '0;
                    leje_d  = REQ_N'(1) << winIdx;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (state_d == ST_GRANT) begin
                    leje_d  = leje_q;
                    valid_d = 1'b1;
                    hold_d  = hold_q + 8'd1;
                end else begin
                    ptr_d     = owner_q + IDX_W'(1);
                    hold_d    = '0;
                    timeout_d = holdExpired & ~ownerRelease;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs, pointer, owner and hold counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            leje_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            leje_q    <= leje_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign Leje    = leje_q;
    assign S       = sel_q;
    assign Indeksi = owner_q;
    assign Valid   = valid_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_arbiter8ne1.sv
// Directed testbench for arbiter8ne1. Three instances share the stimulus:
// A uses the default hold limit (16), B uses MAX_HOLD=4, C uses MAX_HOLD=0.
// Every test starts with a reset so the instances start aligned.
module tb_arbiter8ne1;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Kerkesa;
    logic [7:0] Lirim;

    logic [7:0] lejeA, lejeB, lejeC;
    logic [2:0] sA, sB, sC;
    logic [2:0] idxA, idxB, idxC;
    logic       validA, validB, validC;
    logic       toA, toB, toC;

    int checks   = 0;
    int failures = 0;

    arbiter8ne1 dutA (
        .Clock(Clock), .Reset(Reset), .Kerkesa(Kerkesa), .Lirim(Lirim),
        .Leje(lejeA), .S(sA), .Indeksi(idxA), .Valid(validA), .Timeout(toA)
    );

    arbiter8ne1 #(.MAX_HOLD(4)) dutB (
        .Clock(Clock), .Reset(Reset), .Kerkesa(Kerkesa), .Lirim(Lirim),
        .Leje(lejeB), .S(sB), .Indeksi(idxB), .Valid(validB), .Timeout(toB)
    );

    arbiter8ne1 #(.MAX_HOLD(0)) dutC (
        .Clock(Clock), .Reset(Reset), .Kerkesa(Kerkesa), .Lirim(Lirim),
        .Leje(lejeC), .S(sC), .Indeksi(idxC), .Valid(validC), .Timeout(toC)
    );

    // 10 ns clock.
    always #5 Clock = ~Clock;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One-cycle reset with all requests and releases cleared.
    task automatic applyReset;
        Reset   = 1'b1;
        Kerkesa = 8'h00;
        Lirim   = 8'h00;
        step(1);
        Reset   = 1'b0;
    endtask

    // Reset values, async reset in the middle of a grant to requester 4, then a clean grant of 0.
    task automatic test_reset;
        Reset   = 1'b1;
        Kerkesa = 8'h00;
        Lirim   = 8'h00;
        #1;
        checks++; if (lejeA !== 8'h00) begin failures++; $display("[TB] FAIL reset_leje: got %h expected 00", lejeA); end
        checks++; if (sA !== 3'b000) begin failures++; $display("[TB] FAIL reset_s: got %b expected 000", sA); end
        checks++; if ({validA, toA, idxA} !== 5'b0) begin failures++; $display("[TB] FAIL reset_misc: got %b expected 00000", {validA, toA, idxA}); end
        step(1);
        Reset   = 1'b0;
        Kerkesa = 8'h10;
        step(1);
        checks++; if (lejeA !== 8'h10) begin failures++; $display("[TB] FAIL g4_leje: got %h expected 10", lejeA); end
        checks++; if (sA !== 3'b111) begin failures++; $display("[TB] FAIL g4_s: got %b expected 111", sA); end
        checks++; if (idxA !== 3'd4 || validA !== 1'b1) begin failures++; $display("[TB] FAIL g4_idx_valid: got %0d/%b expected 4/1", idxA, validA); end
        step(1);
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (lejeA !== 8'h00) begin failures++; $display("[TB] FAIL midrst_leje: got %h expected 00", lejeA); end
        checks++; if (sA !== 3'b000 || idxA !== 3'd0) begin failures++; $display("[TB] FAIL midrst_s_idx: got %b/%0d expected 000/0", sA, idxA); end
        checks++; if (validA !== 1'b0 || toA !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid_to: got %b/%b expected 0/0", validA, toA); end
        checks++; if (dutA.ptr_q !== 3'd0) begin failures++; $display("[TB] FAIL midrst_ptr: got %0d expected 0", dutA.ptr_q); end
        Kerkesa = 8'h01;
        step(1);
        Reset = 1'b0;
        step(1);
        checks++; if (lejeA !== 8'h01 || sA !== 3'b000) begin failures++; $display("[TB] FAIL g0_after_rst: got %h/%b expected 01/000", lejeA, sA); end
        checks++; if (validA !== 1'b1 || idxA !== 3'd0) begin failures++; $display("[TB] FAIL g0_valid_idx: got %b/%0d expected 1/0", validA, idxA); end
    endtask

    // All eight requesting, each owner releases after 2 cycles: full rotation plus wrap to 0.
    task automatic test_round_robin;
        logic [2:0] selExp [0:8] = '{3'b000, 3'b010, 3'b100, 3'b011, 3'b111, 3'b001, 3'b101, 3'b110, 3'b000};
        int         ordExp [0:8] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        logic [7:0] expLeje;
        applyReset();
        Kerkesa = 8'hFF;
        step(1);
        for (int g = 0; g < 9; g++) begin
            expLeje = 8'h01 << ordExp[g];
            checks++; if (lejeA !== expLeje) begin failures++; $display("[TB] FAIL rr_leje[%0d]: got %h expected %h", g, lejeA, expLeje); end
            checks++; if (sA !== selExp[g]) begin failures++; $display("[TB] FAIL rr_s[%0d]: got %b expected %b", g, sA, selExp[g]); end
            checks++; if (idxA !== 3'(ordExp[g]) || validA !== 1'b1) begin failures++; $display("[TB] FAIL rr_idx_valid[%0d]: got %0d/%b expected %0d/1", g, idxA, validA, ordExp[g]); end
            step(1);
            checks++; if (validA !== 1'b1 || lejeA !== expLeje) begin failures++; $display("[TB] FAIL rr_hold2[%0d]: got %b/%h expected 1/%h", g, validA, lejeA, expLeje); end
            Lirim = expLeje;
            step(1);
            Lirim = 8'h00;
            checks++; if (validA !== 1'b0 || lejeA !== 8'h00) begin failures++; $display("[TB] FAIL rr_gap1[%0d]: got %b/%h expected 0/00", g, validA, lejeA); end
            checks++; if (sA !== selExp[g]) begin failures++; $display("[TB] FAIL rr_s_hold[%0d]: got %b expected %b", g, sA, selExp[g]); end
            step(1);
            checks++; if (validA !== 1'b0) begin failures++; $display("[TB] FAIL rr_gap2[%0d]: got %b expected 0", g, validA); end
            step(1);
        end
    endtask

    // MAX_HOLD=4: requester 3 never releases, 5 arrives during the grant.
    task automatic test_timeout;
        applyReset();
        Kerkesa = 8'h08;
        step(1);
        checks++; if (lejeB !== 8'h08 || sB !== 3'b011 || validB !== 1'b1) begin failures++; $display("[TB] FAIL to_grant3: got %h/%b/%b expected 08/011/1", lejeB, sB, validB); end
        Kerkesa = 8'h28;
        for (int i = 2; i <= 4; i++) begin
            step(1);
            checks++; if (validB !== 1'b1 || toB !== 1'b0 || lejeB !== 8'h08) begin failures++; $display("[TB] FAIL to_hold[%0d]: got %b/%b/%h expected 1/0/08", i, validB, toB, lejeB); end
        end
        step(1);
        checks++; if (validB !== 1'b0 || toB !== 1'b1 || lejeB !== 8'h00) begin failures++; $display("[TB] FAIL to_pulse: got %b/%b/%h expected 0/1/00", validB, toB, lejeB); end
        step(1);
        checks++; if (toB !== 1'b0 || validB !== 1'b0) begin failures++; $display("[TB] FAIL to_pulse_end: got %b/%b expected 0/0", toB, validB); end
        step(1);
        checks++; if (lejeB !== 8'h20 || sB !== 3'b001 || idxB !== 3'd5) begin failures++; $display("[TB] FAIL to_next5: got %h/%b/%0d expected 20/001/5", lejeB, sB, idxB); end
    endtask

    // MAX_HOLD=4: non-owner release is ignored; owner release on the expiry cycle wins over timeout.
    task automatic test_simultaneous;
        applyReset();
        Kerkesa = 8'h04;
        step(1);
        Lirim = 8'h01;
        step(1);
        Lirim = 8'h00;
        checks++; if (lejeB !== 8'h04 || validB !== 1'b1) begin failures++; $display("[TB] FAIL sim_nonowner: got %h/%b expected 04/1", lejeB, validB); end
        step(2);
        checks++; if (validB !== 1'b1) begin failures++; $display("[TB] FAIL sim_last_cycle: got %b expected 1", validB); end
        Lirim = 8'h04;
        step(1);
        Lirim = 8'h00;
        checks++; if (validB !== 1'b0 || toB !== 1'b0) begin failures++; $display("[TB] FAIL sim_no_timeout: got %b/%b expected 0/0", validB, toB); end
        step(1);
        checks++; if (toB !== 1'b0) begin failures++; $display("[TB] FAIL sim_no_timeout2: got %b expected 0", toB); end
    endtask

    // Requester 6 drops its request mid-grant while 7 and 2 become pending.
    task automatic test_drop;
        applyReset();
        Kerkesa = 8'h40;
        step(1);
        checks++; if (lejeA !== 8'h40 || sA !== 3'b101 || idxA !== 3'd6) begin failures++; $display("[TB] FAIL drop_grant6: got %h/%b/%0d expected 40/101/6", lejeA, sA, idxA); end
        Kerkesa = 8'h84;
        step(1);
        checks++; if (validA !== 1'b0 || lejeA !== 8'h00) begin failures++; $display("[TB] FAIL drop_turn: got %b/%h expected 0/00", validA, lejeA); end
        checks++; if (dutA.ptr_q !== 3'd7) begin failures++; $display("[TB] FAIL drop_ptr: got %0d expected 7", dutA.ptr_q); end
        step(2);
        checks++; if (lejeA !== 8'h80 || sA !== 3'b110 || idxA !== 3'd7) begin failures++; $display("[TB] FAIL drop_grant7: got %h/%b/%0d expected 80/110/7", lejeA, sA, idxA); end
        Lirim = 8'h80;
        step(1);
        Lirim = 8'h00;
        step(2);
        checks++; if (lejeA !== 8'h04 || sA !== 3'b100 || idxA !== 3'd2) begin failures++; $display("[TB] FAIL drop_grant2: got %h/%b/%0d expected 04/100/2", lejeA, sA, idxA); end
    endtask

    // MAX_HOLD=0: requester 1 keeps the grant for 300 cycles without a timeout.
    task automatic test_no_limit;
        applyReset();
        Kerkesa = 8'h02;
        step(1);
        for (int i = 0; i < 300; i++) begin
            checks++; if (lejeC !== 8'h02 || toC !== 1'b0 || validC !== 1'b1) begin failures++; $display("[TB] FAIL nolimit[%0d]: got %h/%b/%b expected 02/0/1", i, lejeC, toC, validC); end
            step(1);
        end
    endtask

    // Run all scenarios in order and print the summary.
    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_drop();
        test_no_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
